// File: rtl/trng_sample_ctrl.sv
// trng_sample_ctrl
// Sequences a ring-oscillator entropy source. It enables the oscillators and waits out
// their warm-up. It then samples the synchronised raw bit at a divided rate, von Neumann
// debiases the samples in pairs, and packs WIDTH accepted bits into a word that is
// delivered over valid/ready. A repetition-count health test watches every raw sample
// and latches a failure state.
`timescale 1ns/1ps

module trng_sample_ctrl #(
  parameter int WIDTH         = 8,
  parameter int WARMUP_CYCLES = 64,
  parameter int SAMPLE_DIV    = 8,
  parameter int REP_LIMIT     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             raw_bit,
  output logic             osc_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             health_fail,
  output logic             busy
);

  // Counter widths. Each counter is wide enough to hold its terminal value.
  localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int BIT_W  = $clog2(WIDTH + 1);
  localparam int REP_W  = $clog2(REP_LIMIT + 1);

  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [REP_W-1:0]  REP_TRIP  = REP_W'(REP_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_SAMPLE,
    S_DELIVER,
    S_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic               sync1, sync2;
  logic [WARM_W-1:0]  warm_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic               have_first;
  logic               first_bit;
  logic [WIDTH-1:0]   acc;
  logic [BIT_W-1:0]   bit_cnt;
  logic [REP_W-1:0]   rep_cnt;
  logic               last_bit;
  logic [WIDTH-1:0]   data_q;

  logic               sample_tick;
  logic               emit;
  logic               word_done;
  logic               trip;
  logic               load_word;
  logic [REP_W-1:0]   rep_next;
  logic [WIDTH-1:0]   word;

  // Sampling strobe, pair decode, word assembly and health-count lookahead.
  always_comb begin
    sample_tick = (state_q == S_SAMPLE) && (div_cnt == DIV_LAST);
    // A second sample that differs from the first emits the first sample's value (10->1, 01->0).
    emit        = sample_tick && have_first && (first_bit != sync2);
    word_done   = emit && (bit_cnt == BIT_LAST);
    word        = acc | (WIDTH'(first_bit) << bit_cnt);
    rep_next    = ((rep_cnt != '0) && (sync2 == last_bit)) ? rep_cnt + 1'b1 : REP_W'(1);
    trip        = sample_tick && (rep_next == REP_TRIP);
  end

  // Next-state selection and state-decoded outputs.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    state_d     = state_q;
    osc_en      = 1'b0;
    out_valid   = 1'b0;
    health_fail = 1'b0;
    busy        = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_WARMUP;
      end
      S_WARMUP: begin
        osc_en = 1'b1;
        if (!run)                       state_d = S_IDLE;
        else if (warm_cnt == WARM_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        osc_en = 1'b1;
        // Health failure outranks a word that completes on the same sample.
        if (!run)           state_d = S_IDLE;
        else if (trip)      state_d = S_FAIL;
        else if (word_done) state_d = S_DELIVER;
      end
      S_DELIVER: begin
        osc_en    = 1'b1;
        out_valid = 1'b1;
        if (!run)           state_d = S_IDLE;
        else if (out_ready) state_d = S_SAMPLE;
      end
      S_FAIL: begin
        health_fail = 1'b1;
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    load_word = (state_q == S_SAMPLE) && (state_d == S_DELIVER);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so that all flops update together at the edge.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Two-flop synchroniser for the asynchronous oscillator output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_bit;
      sync2 <= sync1;
    end
  end

  // Warm-up counter. It runs only in WARMUP, so it is zero on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   warm_cnt <= '0;
    else if (state_q != S_WARMUP) warm_cnt <= '0;
    else                          warm_cnt <= warm_cnt + 1'b1;
  end

  // Sample divider. It is held at zero outside SAMPLE, so it restarts after DELIVER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      div_cnt <= '0;
    else if (state_q != S_SAMPLE)    div_cnt <= '0;
    else if (div_cnt == DIV_LAST)    div_cnt <= '0;
    else                             div_cnt <= div_cnt + 1'b1;
  end

  // Pair register and bit accumulator. They are discarded whenever no word is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_first <= 1'b0;
      first_bit  <= 1'b0;
      acc        <= '0;
      bit_cnt    <= '0;
    end else if ((state_q != S_SAMPLE) && (state_q != S_DELIVER)) begin
      have_first <= 1'b0;
      first_bit  <= 1'b0;
      acc        <= '0;
      bit_cnt    <= '0;
    end else if (sample_tick) begin
      if (!have_first) begin
        have_first <= 1'b1;
        first_bit  <= sync2;
      end else begin
        have_first <= 1'b0;
        if (word_done) begin
          acc     <= '0;
          bit_cnt <= '0;
        end else if (emit) begin
          acc     <= word;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Repetition count over every raw sample. It survives DELIVER and restarts after IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (state_q == S_IDLE) begin
      rep_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (sample_tick) begin
      rep_cnt  <= rep_next;
      last_bit <= sync2;
    end
  end

  // Output word register. It loads only when a completed word goes to DELIVER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         data_q <= '0;
    else if (load_word) data_q <= word;
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// tb_trng_sample_ctrl
// Directed bench for trng_sample_ctrl. The raw bit is driven on falling edges, one value
// per sampling window, so each sample sees a settled value through the synchroniser.
`timescale 1ns/1ps

module tb_trng_sample_ctrl;

  localparam int WIDTH         = 8;
  localparam int WARMUP_CYCLES = 64;
  localparam int SAMPLE_DIV    = 8;
  localparam int REP_LIMIT     = 16;

  logic             clk;
  logic             rst_n;
  logic             run;
  logic             raw_bit;
  logic             osc_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             health_fail;
  logic             busy;

  int checks = 0;
  int errors = 0;

  trng_sample_ctrl #(
    .WIDTH         (WIDTH),
    .WARMUP_CYCLES (WARMUP_CYCLES),
    .SAMPLE_DIV    (SAMPLE_DIV),
    .REP_LIMIT     (REP_LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .raw_bit     (raw_bit),
    .osc_en      (osc_en),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .health_fail (health_fail),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives a stream of raw samples written as "10 01 ..." one window at a time.
  // The task must start on the falling edge just after SAMPLE is entered. The last
  // sample must complete a word. The task checks that out_valid is still low one cycle
  // before that sample and is high with the expected word right after it.
  task automatic feed_word(input string pairs, input logic [WIDTH-1:0] exp, input string tag);
    int  n;
    int  k;
    byte c;
    n = 0;
    for (int i = 0; i < pairs.len(); i++) begin
      c = pairs[i];
      if (c == "0" || c == "1") n++;
    end
    k = 0;
    for (int i = 0; i < pairs.len(); i++) begin
      c = pairs[i];
      if (c == "0" || c == "1") begin
        raw_bit = (c == "1");
        k++;
        if (k < n) begin
          repeat (SAMPLE_DIV) @(negedge clk);
        end else begin
          repeat (SAMPLE_DIV - 1) @(negedge clk);
          check({tag, "_valid_early"}, out_valid, 0);
          @(negedge clk);
          check({tag, "_valid"}, out_valid, 1);
          check({tag, "_data"}, out_data, exp);
        end
      end
    end
  endtask

  // Watchdog: the directed sequence is a few thousand cycles at most.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    run       = 1'b0;
    raw_bit   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_osc_en",      osc_en,      0);
    check("rst_out_data",    out_data,    0);
    check("rst_out_valid",   out_valid,   0);
    check("rst_health_fail", health_fail, 0);
    check("rst_busy",        busy,        0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: asynchronous reset with three bits accumulated.
    run = 1'b1;
    repeat (WARMUP_CYCLES + 1) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      raw_bit = (i == 0 || i == 3 || i == 4);   // samples 1 0 0 1 1 0 -> pairs 10 01 10
      repeat (SAMPLE_DIV) @(negedge clk);
    end
    check("t1_busy_before",   busy,   1);
    check("t1_osc_en_before", osc_en, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t1_osc_en",      osc_en,      0);
    check("t1_out_data",    out_data,    0);
    check("t1_out_valid",   out_valid,   0);
    check("t1_health_fail", health_fail, 0);
    check("t1_busy",        busy,        0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 2: first word arrives WARMUP + 16 samples after run, LSB first.
    run = 1'b1;
    @(negedge clk);
    check("t2_warm_osc_en", osc_en,    1);
    check("t2_warm_busy",   busy,      1);
    check("t2_warm_valid",  out_valid, 0);
    repeat (WARMUP_CYCLES) @(negedge clk);
    feed_word("10 01 10 10 01 01 10 01", 8'h4D, "t2");

    // Test 4: stall for 50 cycles while the raw input toggles. Nothing may be sampled.
    for (int i = 1; i <= 50; i++) begin
      raw_bit = ~raw_bit;
      @(negedge clk);
      if (i % 10 == 0) begin
        check("t4_hold_valid", out_valid, 1);
        check("t4_hold_data",  out_data,  8'h4D);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_valid_drop", out_valid, 0);
    check("t4_osc_en",     osc_en,    1);
    check("t4_busy",       busy,      1);
    out_ready = 1'b0;

    // Test 3: discarded 00/11 pairs only add latency. The exact timing also shows
    // that the divider restarted at zero after the handshake.
    feed_word("10 00 01 11 10 10 00 01 01 10 11 01", 8'h4D, "t3");

    // Test 6: drop run while in DELIVER.
    run = 1'b0;
    @(negedge clk);
    check("t6_out_valid", out_valid, 0);
    check("t6_osc_en",    osc_en,    0);
    check("t6_busy",      busy,      0);

    // Test 5: stuck-at-1 source trips the repetition test on the REP_LIMIT-th sample.
    run     = 1'b1;
    raw_bit = 1'b1;
    repeat (WARMUP_CYCLES + REP_LIMIT * SAMPLE_DIV) @(negedge clk);
    check("t5_fail_early",  health_fail, 0);
    check("t5_valid_early", out_valid,   0);
    @(negedge clk);
    check("t5_health_fail", health_fail, 1);
    check("t5_osc_en",      osc_en,      0);
    check("t5_out_valid",   out_valid,   0);
    check("t5_busy",        busy,        1);
    repeat (5) @(negedge clk);
    check("t5_sticky",      health_fail, 1);
    run = 1'b0;
    @(negedge clk);
    check("t5_clear_fail",  health_fail, 0);
    check("t5_clear_busy",  busy,        0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
